// File: rtl/core_msg_receiver.sv
// Core-side end of the scheduler-to-core message bus.
// It decodes the broadcast stream and captures this core's selection, its r0 init
// word and its instruction words. Instructions go into a local first-word-fall-through
// FIFO. core_ready tells the scheduler whether this core currently owns a task.
module core_msg_receiver #(
  parameter int CORE_ID    = 0,
  parameter int CORE_NUM   = 16,
  parameter int BUS_W      = 16,
  parameter int R0_WORDS   = 16,
  parameter int IBUF_DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BUS_W-1:0] mess_to_core,
  input  logic             core_mask_loading,
  input  logic             r0_mask_loading,
  input  logic             r0_loading,
  input  logic             if_loading,
  output logic             core_ready,
  output logic [BUS_W-1:0] r0_value,
  output logic             r0_valid,
  output logic [BUS_W-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             exec_done,
  output logic             proto_err,
  output logic             ovf_err
);

  localparam int CW = (R0_WORDS > 1) ? $clog2(R0_WORDS) : 1;
  localparam int AW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  // Bit of a mask word that addresses this core (CORE_ID is always below CORE_NUM).
  localparam int SEL_BIT = CORE_ID % CORE_NUM;
  localparam logic [CW-1:0] ID_CNT   = CW'(CORE_ID);
  localparam logic [CW-1:0] LAST_CNT = CW'(R0_WORDS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_MASK, ST_R0, ST_IF, ST_EXEC} state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             r0_sel_q, r0_sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             prev_if_q, prev_if_d;
  logic             core_ready_q, core_ready_d;
  logic [BUS_W-1:0] r0_value_q, r0_value_d;
  logic             r0_valid_q, r0_valid_d;
  logic             proto_err_q, proto_err_d;
  logic             ovf_err_q, ovf_err_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  logic [BUS_W-1:0] mem [IBUF_DEPTH];
  logic [2:0]       n_strobes;
  logic             any_strobe, multi_strobe, mask_bit;
  logic             fifo_empty, fifo_full, push, pop;

  assign n_strobes    = 3'(core_mask_loading) + 3'(r0_mask_loading) + 3'(r0_loading) + 3'(if_loading);
  assign any_strobe   = (n_strobes != 3'd0);
  assign multi_strobe = (n_strobes > 3'd1);
  assign mask_bit     = mess_to_core[SEL_BIT];
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop          = !fifo_empty && instr_ready && (state_q == ST_IF || state_q == ST_EXEC);

  // Next-state decode: strobe checking, per-state capture and FIFO push/pop control.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    r0_sel_d    = r0_sel_q;
    cnt_d       = cnt_q;
    prev_if_d   = 1'b0;
    r0_value_d  = r0_value_q;
    r0_valid_d  = 1'b0;
    proto_err_d = proto_err_q;
    ovf_err_d   = ovf_err_q;
    push        = 1'b0;
    if (multi_strobe) begin
      proto_err_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (core_mask_loading) begin
            sel_d   = mask_bit;
            state_d = ST_MASK;
          end else if (any_strobe) begin
            proto_err_d = 1'b1;
          end
        end
        ST_MASK: begin
          if (r0_mask_loading) begin
            r0_sel_d = mask_bit;
            cnt_d    = '0;
            state_d  = ST_R0;
          end else if (any_strobe) begin
            proto_err_d = 1'b1;
          end
        end
        ST_R0: begin
          if (r0_loading) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ID_CNT && sel_q && r0_sel_q) begin
              r0_value_d = mess_to_core;
              r0_valid_d = 1'b1;
            end
            if (cnt_q == LAST_CNT) state_d = ST_IF;
          end else if (any_strobe) begin
            proto_err_d = 1'b1;
          end
        end
        ST_IF: begin
          if (if_loading) begin
            prev_if_d = 1'b1;
            if (sel_q) begin
              if (fifo_full && !pop) ovf_err_d = 1'b1;
              else                   push = 1'b1;
            end
          end else if (core_mask_loading && prev_if_q) begin
            // Back-to-back task: an unselected core starts the new task at once;
            // a selected core still owes its own task, so it goes to EXEC and the
            // word is treated like any mask seen while executing.
            if (sel_q) begin
              state_d = ST_EXEC;
              if (mask_bit) proto_err_d = 1'b1;
            end else begin
              sel_d   = mask_bit;
              state_d = ST_MASK;
            end
          end else if (any_strobe) begin
            proto_err_d = 1'b1;
          end else if (prev_if_q) begin
            state_d = sel_q ? ST_EXEC : ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (core_mask_loading && mask_bit) proto_err_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_q == ST_EXEC && exec_done) begin
      if (fifo_empty) state_d = ST_IDLE;
      else            proto_err_d = 1'b1;
    end
    wr_ptr_d     = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d     = rd_ptr_q + (AW+1)'(pop);
    core_ready_d = (state_d != ST_EXEC);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      r0_sel_q     <= 1'b0;
      cnt_q        <= '0;
      prev_if_q    <= 1'b0;
      core_ready_q <= 1'b1;
      r0_value_q   <= '0;
      r0_valid_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      ovf_err_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      r0_sel_q     <= r0_sel_d;
      cnt_q        <= cnt_d;
      prev_if_q    <= prev_if_d;
      core_ready_q <= core_ready_d;
      r0_value_q   <= r0_value_d;
      r0_valid_q   <= r0_valid_d;
      proto_err_q  <= proto_err_d;
      ovf_err_q    <= ovf_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Instruction storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr_q[AW-1:0]] <= mess_to_core;
  end

  assign instr       = fifo_empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign instr_valid = !fifo_empty;
  assign core_ready  = core_ready_q;
  assign r0_value    = r0_value_q;
  assign r0_valid    = r0_valid_q;
  assign proto_err   = proto_err_q;
  assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_core_msg_receiver.sv
// Scoreboard bench for core_msg_receiver with CORE_ID=3: the stimulus pushes the
// expected r0 words and instructions into queues, and a negedge monitor compares
// every r0_valid pulse and every popped FIFO head against those queues.
module tb_core_msg_receiver;

  localparam logic [3:0] S_CM = 4'b1000, S_RM = 4'b0100, S_R0 = 4'b0010, S_IF = 4'b0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mess_to_core = '0;
  logic        core_mask_loading = 1'b0, r0_mask_loading = 1'b0, r0_loading = 1'b0, if_loading = 1'b0;
  logic        core_ready, r0_valid, instr_valid, proto_err, ovf_err;
  logic [15:0] r0_value, instr;
  logic        instr_ready = 1'b1;
  logic        exec_done = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [15:0] r0_q[$];
  logic [15:0] instr_q[$];

  core_msg_receiver #(.CORE_ID(3)) dut (
    .clk(clk), .reset(reset), .mess_to_core(mess_to_core),
    .core_mask_loading(core_mask_loading), .r0_mask_loading(r0_mask_loading),
    .r0_loading(r0_loading), .if_loading(if_loading),
    .core_ready(core_ready), .r0_value(r0_value), .r0_valid(r0_valid),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .exec_done(exec_done), .proto_err(proto_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: compares every r0 pulse and every FIFO pop with the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (r0_valid) begin
        if (r0_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r0_unexpected: got r0_valid=1 r0_value=%h, required no pulse", r0_value);
        end else chk("r0_value", {16'h0, r0_value}, {16'h0, r0_q.pop_front()});
      end
      if (instr_valid && instr_ready) begin
        if (instr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL instr_unexpected: got instr=%h, required empty FIFO", instr);
        end else chk("instr", {16'h0, instr}, {16'h0, instr_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [3:0] s, input logic [15:0] w);
    @(posedge clk); #1;
    {core_mask_loading, r0_mask_loading, r0_loading, if_loading} = s;
    mess_to_core = w;
  endtask

  task automatic idle1();
    send(4'b0000, 16'h0);
  endtask

  task automatic do_reset();
    chk("r0_queue_drained", r0_q.size(), 0);
    chk("instr_queue_drained", instr_q.size(), 0);
    @(posedge clk); #1; reset = 1'b1;
    {core_mask_loading, r0_mask_loading, r0_loading, if_loading} = 4'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b0;
    chk("rst_core_ready", core_ready, 1);
    chk("rst_r0_value", r0_value, 0);
    chk("rst_r0_valid", r0_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_ovf_err", ovf_err, 0);
  endtask

  // Core mask, r0 mask and the 16 r0 words (word k = base+k).
  task automatic load_head(input logic [15:0] cm, input logic [15:0] rm, input logic [15:0] base);
    send(S_CM, cm);
    send(S_RM, rm);
    for (int k = 0; k < 16; k++) begin
      if (k == 3 && cm[3] && rm[3]) r0_q.push_back(base + 16'(k));
      send(S_R0, base + 16'(k));
    end
  endtask

  task automatic load_if(input logic [15:0] base, input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      if (sel && i < 64) instr_q.push_back(base + 16'(i));
      send(S_IF, base + 16'(i));
    end
  endtask

  // Idle cycle that closes the stream, then check core_ready latency.
  task automatic end_stream(input bit sel);
    idle1();
    chk("rdy_at_end_cycle", core_ready, 1);
    @(posedge clk); #1;
    chk("rdy_after_end", core_ready, {31'h0, !sel});
  endtask

  task automatic finish_exec();
    int n;
    n = 0;
    while (instr_valid && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_in_time", instr_valid, 0);
    chk("rdy_in_exec", core_ready, 0);
    exec_done = 1'b1;
    @(posedge clk); #1;
    exec_done = 1'b0;
    chk("rdy_after_done", core_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Selected task: r0 word 3 and four instructions.
    load_head(16'h0008, 16'h0008, 16'h1000);
    load_if(16'hA000, 4, 1);
    end_stream(1);
    finish_exec();
    chk("t1_proto_err", proto_err, 0);

    // Unselected core walks the stream and discards everything.
    load_head(16'h0004, 16'h0008, 16'h1000);
    load_if(16'hA000, 4, 0);
    end_stream(0);
    chk("t2_instr_valid", instr_valid, 0);
    repeat (2) idle1();
    chk("t2_core_ready", core_ready, 1);

    // Selected but r0 mask clear: no r0 pulse, instructions still captured.
    load_head(16'h0008, 16'h0000, 16'h1100);
    load_if(16'hB000, 4, 1);
    end_stream(1);
    finish_exec();
    chk("t3_proto_err", proto_err, 0);

    // Overflow: 65 words with the core not popping.
    instr_ready = 1'b0;
    load_head(16'h0008, 16'h0008, 16'h2000);
    load_if(16'hC000, 65, 1);
    end_stream(1);
    chk("t4_ovf_err", ovf_err, 1);
    chk("t4_instr_valid", instr_valid, 1);
    chk("t4_head", instr, 16'hC000);
    instr_ready = 1'b1;
    finish_exec();
    do_reset();

    // Two strobes together in R0: flagged, word ignored, count unchanged.
    send(S_CM, 16'h0008);
    send(S_RM, 16'h0008);
    send(S_R0, 16'h3000);
    send(S_R0, 16'h3001);
    send(S_R0 | S_IF, 16'hDEAD);
    idle1();
    chk("t5_proto_multi", proto_err, 1);
    for (int k = 2; k < 16; k++) begin
      if (k == 3) r0_q.push_back(16'h3003);
      send(S_R0, 16'h3000 + 16'(k));
    end
    load_if(16'hE100, 2, 1);
    end_stream(1);
    chk("t5_proto_sticky", proto_err, 1);
    finish_exec();
    do_reset();

    // Task collision while executing.
    load_head(16'h0008, 16'h0008, 16'h5000);
    load_if(16'hE000, 2, 1);
    end_stream(1);
    chk("t6_proto_clean", proto_err, 0);
    send(S_CM, 16'h0004);
    idle1();
    chk("t6_other_core_mask", proto_err, 0);
    send(S_CM, 16'h0008);
    idle1();
    chk("t6_collision", proto_err, 1);
    chk("t6_still_exec", core_ready, 0);
    finish_exec();
    do_reset();

    // Back-to-back tasks: unselected then selected.
    load_head(16'h0004, 16'h0004, 16'h6000);
    load_if(16'hF000, 2, 0);
    load_head(16'h0008, 16'h0008, 16'h7000);
    load_if(16'hD000, 3, 1);
    end_stream(1);
    finish_exec();
    chk("t7_proto_err", proto_err, 0);
    chk("t7_r0_value", r0_value, 16'h7003);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
